// File: rtl/sctag_cpx_reqctl.sv
// Outbound CPX request control: 4-entry packet queue, per-destination credit
// tracking (CPX queue depth 2) and atomic-pair issue sequencing.
module sctag_cpx_reqctl (
  input  logic       rclk,
  input  logic       arst,
  input  logic       pkt_vld,
  input  logic [2:0] pkt_dest,
  input  logic       pkt_atom,
  input  logic [7:0] cpx_sctag_grant_cx,
  output logic [7:0] sctag_cpx_req_cq,
  output logic       sctag_cpx_atom_cq,
  output logic [1:0] sctag_cpx_pkt_ptr,
  output logic       oq_full,
  output logic       reqctl_err
);

  logic [3:0][2:0] fifo_dest_q, fifo_dest_d;
  logic [3:0]      fifo_atom_q, fifo_atom_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0][1:0] out_q, out_d;
  logic            pair_q, pair_d;
  logic [2:0]      pair_dest_q, pair_dest_d;
  logic [7:0]      req_q, req_d;
  logic            req_atom_q, req_atom_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            err_q, err_d;

  logic       issue, iss_atom, push, head_atom;
  logic [2:0] iss_dest, head_dest;

  always_comb begin
    fifo_dest_d = fifo_dest_q;
    fifo_atom_d = fifo_atom_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pair_d      = pair_q;
    pair_dest_d = pair_dest_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    out_d       = out_q;
    issue       = 1'b0;
    iss_atom    = 1'b0;
    iss_dest    = pair_dest_q;
    head_dest   = fifo_dest_q[rd_ptr_q];
    head_atom   = fifo_atom_q[rd_ptr_q];
    push        = pkt_vld && (cnt_q != 3'd4);

    // Second half of a pair is forced out the edge after the first; it always
    // goes to the first half's destination even if its own dest disagrees.
    if (pair_q) begin
      issue  = 1'b1;
      pair_d = 1'b0;
      if (head_dest != pair_dest_q) err_d = 1'b1;
    end else if (cnt_q != 3'd0) begin
      iss_dest = head_dest;
      if (head_atom) begin
        if (cnt_q >= 3'd2 && out_q[head_dest] == 2'd0) begin
          issue       = 1'b1;
          iss_atom    = 1'b1;
          pair_d      = 1'b1;
          pair_dest_d = head_dest;
        end
      end else if (out_q[head_dest] != 2'd2) begin
        issue = 1'b1;
      end
    end

    if (pkt_vld && !push) err_d = 1'b1;

    // Grants are judged against the pre-edge count; a stray grant is ignored.
    for (int d = 0; d < 8; d++) begin
      if (cpx_sctag_grant_cx[d] && out_q[d] == 2'd0) err_d = 1'b1;
      out_d[d] = out_q[d]
               + {1'b0, issue && (iss_dest == 3'(d))}
               - {1'b0, cpx_sctag_grant_cx[d] && (out_q[d] != 2'd0)};
    end

    if (push) begin
      fifo_dest_d[wr_ptr_q] = pkt_dest;
      fifo_atom_d[wr_ptr_q] = pkt_atom;
      wr_ptr_d              = wr_ptr_q + 2'd1;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      ptr_d    = rd_ptr_q;
    end
    cnt_d      = cnt_q + {2'b0, push} - {2'b0, issue};
    req_d      = issue ? (8'b1 << iss_dest) : 8'h00;
    req_atom_d = iss_atom;
  end

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      fifo_dest_q <= '0;
      fifo_atom_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      pair_q      <= 1'b0;
      pair_dest_q <= '0;
      req_q       <= '0;
      req_atom_q  <= 1'b0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      fifo_dest_q <= fifo_dest_d;
      fifo_atom_q <= fifo_atom_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      pair_q      <= pair_d;
      pair_dest_q <= pair_dest_d;
      req_q       <= req_d;
      req_atom_q  <= req_atom_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  assign sctag_cpx_req_cq  = req_q;
  assign sctag_cpx_atom_cq = req_atom_q;
  assign sctag_cpx_pkt_ptr = ptr_q;
  assign oq_full           = (cnt_q == 3'd4);
  assign reqctl_err        = err_q;

endmodule

// File: tb/tb_sctag_cpx_reqctl.sv
// Bench for sctag_cpx_reqctl: queue/credit reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sctag_cpx_reqctl;

  logic       rclk = 1'b0;
  logic       arst = 1'b1;
  logic       pkt_vld = 1'b0;
  logic [2:0] pkt_dest = '0;
  logic       pkt_atom = 1'b0;
  logic [7:0] grant = '0;
  logic [7:0] req;
  logic       atom;
  logic [1:0] ptr;
  logic       full;
  logic       err;

  int total = 0;
  int bad   = 0;

  sctag_cpx_reqctl dut (
    .rclk              (rclk),
    .arst              (arst),
    .pkt_vld           (pkt_vld),
    .pkt_dest          (pkt_dest),
    .pkt_atom          (pkt_atom),
    .cpx_sctag_grant_cx(grant),
    .sctag_cpx_req_cq  (req),
    .sctag_cpx_atom_cq (atom),
    .sctag_cpx_pkt_ptr (ptr),
    .oq_full           (full),
    .reqctl_err        (err)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending packets, credit counts, pair state.
  typedef struct { logic [2:0] d; logic a; } ent_t;
  ent_t       q[$];
  int         outc[8];
  bit         pend;
  logic [2:0] pdest;
  int         rd;
  logic [7:0] e_req;
  logic       e_atom, e_err;
  logic [1:0] e_ptr;
  int         n;
  bit         iss, ia;
  logic [2:0] id;
  ent_t       ne;

  always @(posedge rclk) begin
    if (arst) begin
      q.delete();
      for (int d = 0; d < 8; d++) outc[d] = 0;
      pend = 0; pdest = 0; rd = 0;
      e_req = 0; e_atom = 0; e_ptr = 0; e_err = 0;
    end else begin
      n = q.size(); iss = 0; ia = 0; id = 0;
      if (pend) begin
        iss = 1; id = pdest; pend = 0;
        if (q[0].d != pdest) e_err = 1;
      end else if (n > 0) begin
        if (q[0].a) begin
          if (n >= 2 && outc[q[0].d] == 0) begin
            iss = 1; ia = 1; id = q[0].d; pend = 1; pdest = q[0].d;
          end
        end else if (outc[q[0].d] < 2) begin
          iss = 1; id = q[0].d;
        end
      end
      for (int d = 0; d < 8; d++)
        if (grant[d]) begin
          if (outc[d] > 0) outc[d]--;
          else e_err = 1;
        end
      e_req = 8'h00; e_atom = ia;
      if (iss) begin
        outc[id]++;
        void'(q.pop_front());
        e_ptr = 2'(rd);
        rd = (rd + 1) % 4;
        e_req = 8'h01 << id;
      end
      if (pkt_vld) begin
        if (n < 4) begin
          ne.d = pkt_dest; ne.a = pkt_atom;
          q.push_back(ne);
        end else e_err = 1;
      end
    end
    #1;
    chk("m_req",  32'(req),  32'(e_req));
    chk("m_atom", 32'(atom), 32'(e_atom));
    chk("m_ptr",  32'(ptr),  32'(e_ptr));
    chk("m_full", 32'(full), 32'(q.size() == 4));
    chk("m_err",  32'(err),  32'(e_err));
  end

  task automatic step(input logic v, input logic [2:0] d, input logic a, input logic [7:0] g);
    @(negedge rclk);
    pkt_vld = v; pkt_dest = d; pkt_atom = a; grant = g;
    @(posedge rclk);
    #2;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 3'd0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    arst = 1'b1; pkt_vld = 1'b0; grant = 8'h00; pkt_atom = 1'b0;
    #1;
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge rclk);
    @(negedge rclk);
    arst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge rclk);
    chk("reset_req",  32'(req),  32'h0);
    chk("reset_atom", 32'(atom), 32'h0);
    chk("reset_ptr",  32'(ptr),  32'h0);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_err",  32'(err),  32'h0);
    arst = 1'b0;

    // Single packet, two-edge latency
    step(1, 3'd5, 0, 8'h00);
    chk("single_lat0", 32'(req), 32'h00);
    step(0, 3'd0, 0, 8'h00);
    chk("single_req", 32'(req), 32'h20);
    chk("single_atom", 32'(atom), 32'h0);
    chk("single_ptr", 32'(ptr), 32'h0);
    step(0, 3'd0, 0, 8'h00);
    chk("single_once", 32'(req), 32'h00);

    // Credit stall at depth 2
    do_reset();
    step(1, 3'd2, 0, 8'h00);
    step(1, 3'd2, 0, 8'h00);
    chk("c2_first", 32'(req), 32'h04);
    chk("c2_ptr0", 32'(ptr), 32'h0);
    step(1, 3'd2, 0, 8'h00);
    chk("c2_second", 32'(req), 32'h04);
    chk("c2_ptr1", 32'(ptr), 32'h1);
    step(0, 3'd0, 0, 8'h00);
    chk("c2_stall", 32'(req), 32'h00);
    chk("c2_ptr_hold", 32'(ptr), 32'h1);
    step(0, 3'd0, 0, 8'h04);
    chk("c2_grant_edge", 32'(req), 32'h00);
    step(0, 3'd0, 0, 8'h00);
    chk("c2_third", 32'(req), 32'h04);
    chk("c2_ptr2", 32'(ptr), 32'h2);

    // Atomic pair waits for zero outstanding
    do_reset();
    step(1, 3'd1, 0, 8'h00);
    step(1, 3'd1, 1, 8'h00);
    step(1, 3'd1, 0, 8'h00);
    step(0, 3'd0, 0, 8'h00);
    chk("at_wait", 32'(req), 32'h00);
    step(0, 3'd0, 0, 8'h02);
    chk("at_wait2", 32'(req), 32'h00);
    step(0, 3'd0, 0, 8'h00);
    chk("at_h1_req", 32'(req), 32'h02);
    chk("at_h1_atom", 32'(atom), 32'h1);
    chk("at_h1_ptr", 32'(ptr), 32'h1);
    step(0, 3'd0, 0, 8'h00);
    chk("at_h2_req", 32'(req), 32'h02);
    chk("at_h2_atom", 32'(atom), 32'h0);
    chk("at_h2_ptr", 32'(ptr), 32'h2);
    chk("at_err", 32'(err), 32'h0);

    // Overflow: dest 3 saturates after two issues
    do_reset();
    for (int i = 1; i <= 6; i++) step(1, 3'd3, 0, 8'h00);
    chk("ovf_full", 32'(full), 32'h1);
    chk("ovf_err0", 32'(err), 32'h0);
    step(1, 3'd3, 0, 8'h00);
    chk("ovf_err1", 32'(err), 32'h1);
    chk("ovf_full2", 32'(full), 32'h1);

    // Stray grant
    do_reset();
    step(0, 3'd0, 0, 8'h80);
    chk("stray_err", 32'(err), 32'h1);

    // Issue and grant to the same dest on one edge
    do_reset();
    step(1, 3'd4, 0, 8'h00);
    step(1, 3'd4, 0, 8'h00);
    step(1, 3'd4, 0, 8'h10);
    step(1, 3'd4, 0, 8'h00);
    chk("net_issue", 32'(req), 32'h10);
    step(0, 3'd0, 0, 8'h00);
    chk("net_stall", 32'(req), 32'h00);
    chk("net_err", 32'(err), 32'h0);

    // Mismatched second-half destination
    do_reset();
    step(1, 3'd0, 1, 8'h00);
    step(1, 3'd1, 0, 8'h00);
    step(0, 3'd0, 0, 8'h00);
    chk("mis_h1", 32'(req), 32'h01);
    step(0, 3'd0, 0, 8'h00);
    chk("mis_h2", 32'(req), 32'h01);
    chk("mis_err", 32'(err), 32'h1);

    // Reset between atomic halves
    do_reset();
    step(1, 3'd6, 1, 8'h00);
    step(1, 3'd6, 0, 8'h00);
    step(0, 3'd0, 0, 8'h00);
    chk("abort_h1", 32'(req), 32'h40);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 3'd0, 0, 8'h00);
      chk("abort_no_h2", 32'(req), 32'h00);
    end

    // Pseudo-random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++)
      step(($urandom % 10) < 7, 3'($urandom % 8), ($urandom % 8) == 0,
           (($urandom % 3) == 0) ? (8'h01 << ($urandom % 8)) : 8'h00);
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sctag_cpx_reqctl.md
SCTAG_CPX_REQCTL -- requirements
Module: sctag_cpx_reqctl

Interface
REQ-001 SHALL have rclk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have arst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have pkt_vld  input  1  pipeline offers one outbound CPX packet this cycle.
REQ-004 SHALL have pkt_dest  input  3  destination CPU queue (0-7) of offered packet.
REQ-005 SHALL have pkt_atom  input  1  offered packet is first of a two-packet atomic pair; the next enqueued packet is its second half, same dest.
REQ-006 SHALL have cpx_sctag_grant_cx  input  8  per-destination grant from CPX; bit d frees one slot in destination queue d.
REQ-007 SHALL have sctag_cpx_req_cq  output  8  one-hot request to CPX for issued packet.
REQ-008 SHALL have sctag_cpx_atom_cq  output  1  qualifies req: first packet of atomic pair.
REQ-009 SHALL have sctag_cpx_pkt_ptr  output  2  queue index of issued packet, valid with any req bit; steers data mux.
REQ-010 SHALL have oq_full  output  1  queue holds 4 entries.
REQ-011 SHALL have reqctl_err  output  1  sticky protocol-error flag.

Function
REQ-012 SHALL hold a 4-entry FIFO of {dest[2:0], atom}; write pointer, read pointer, 3-bit count 0-4; pointers wrap 3->0.
REQ-013 SHALL enqueue at a rising edge when pkt_vld=1 and count<4 (registered count; same-edge dequeue does not admit a packet while full).
REQ-014 SHALL drop pkt_vld while full and set reqctl_err.
REQ-015 SHALL keep a per-destination outstanding counter out[d], range 0-2 (CPX destination queue depth 2).
REQ-016 SHALL issue non-atomic head entry when count>=1 and out[dest]<2.
REQ-017 SHALL issue atomic head entry only when count>=2 and out[dest]=0; otherwise head waits (no bypass, strict FIFO order).
REQ-018 SHALL register outputs: issue decided from state at edge e drives req/atom/ptr during cycle after e; req=onehot(dest), ptr=read pointer.
REQ-019 Atomic pair SHALL occupy two consecutive cycles: cycle 1 req=onehot(dest), atom=1, ptr=p; cycle 2 req=same onehot, atom=0, ptr=p+1; no other issue between or during.
REQ-020 SHALL set reqctl_err if the second half of a pair carries a different dest; the pair still issues to the first dest.
REQ-021 Each issued packet SHALL increment out[dest] and advance read pointer/decrement count at the issuing edge.
REQ-022 Each set grant bit d SHALL decrement out[d]; grants on multiple bits in one cycle all apply.
REQ-023 Simultaneous issue and grant to the same d SHALL net to zero change.
REQ-024 Grant to d with out[d]=0 SHALL be ignored (counter stays 0) and set reqctl_err.
REQ-025 Minimum latency: packet enqueued at edge k into empty queue with credit drives req during cycle after edge k+1.
REQ-026 Throughput: one non-atomic packet per cycle while credits allow.
REQ-027 sctag_cpx_req_cq SHALL be all-zero and atom=0 in any cycle with no issue; ptr holds last value.

Reset
REQ-028 arst=1 SHALL immediately clear FIFO pointers, count, all out[d], in-progress atomic-pair state, req=0, atom=0, ptr=0, oq_full=0, reqctl_err=0.
REQ-029 arst asserted between halves of an atomic pair SHALL abort the pair; second half is never issued.
REQ-030 Packets offered while arst=1 SHALL be discarded; first enqueue occurs on first rising edge with arst=0.

Verification
REQ-031 Single packet dest=5 into empty queue -> req=8'h20, atom=0, ptr=0 exactly one cycle, two edges after enqueue; out[5]=1.
REQ-032 Three packets dest=2, no grants -> two issue back-to-back (req=8'h04), third stalls; grant bit2 once -> third issues next cycle.
REQ-033 Atomic pair dest=1 with out[1]=1 -> no issue; grant bit1 -> req=8'h02 atom=1 ptr=p, then req=8'h02 atom=0 ptr=p+1.
REQ-034 Five enqueues, no issue possible -> oq_full=1 after 4th, 5th dropped, reqctl_err=1.
REQ-035 Grant bit7 with out[7]=0 -> out[7] stays 0, reqctl_err=1; issue+grant same dest same edge -> out unchanged.
REQ-036 arst pulsed between atomic halves -> req=0, all state cleared, no second half after release.
